joypad_port: RTL

Controller interface for the CPU bus at $4016/$4017. It sits beside the cartridge on the `$4xxx` decode and returns data on the core read-data mux. A scanner FSM polls up to two physical NES pads through a latch/clock/serial-data interface and commits each 8-button result atomically. A host-side strobe/shift register reproduces the standard $4016/$4017 read semantics for the core.

---
 rtl/joypad_port.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/joypad_port.sv
// Controller port for $4016/$4017: a scanner FSM polls NES pads serially, and a strobe/shift register serves CPU reads.
// Optional second pad is built when JOYPAD_PAD2_EN is defined.
`timescale 1ns/1ps
module joypad_port #(
    parameter int P_half = 64,
    parameter int P_poll = 16384
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_host_addr,
    input  logic        I_host_wren,
    input  logic        I_host_rden,
    input  logic [7:0]  I_host_data,
    output logic [7:0]  O_host_data,
    output logic        O_pad_latch,
    output logic        O_pad_clock,
    input  logic [1:0]  I_pad_data,
    output logic [15:0] O_pad_state
);

`ifdef JOYPAD_PAD2_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    localparam int CMAX = (P_poll > 2*P_half) ? P_poll : 2*P_half;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] POLL_END  = CW'(P_poll - 1);
    localparam logic [CW-1:0] LATCH_END = CW'(2*P_half - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(P_half - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SAMPLE, S_CLK_HI, S_CLK_LO, S_COMMIT
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         idx_q;
    logic               latch_q, pclk_q;
    logic [NP-1:0]      sync1_q, sync2_q;
    logic [NP-1:0][7:0] asm_q, snap_q, shift_q;

    logic wren_q, rden_q, rd_addr_q, strobe_q;
    logic wr_4016, rd_fall, strobe_d;

    logic unused_host_bits;
    assign unused_host_bits = ^I_host_data[7:1];

    // Pads idle high (released); the flops reset to 1 so nothing reads as pressed.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= I_pad_data[NP-1:0];
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
            asm_q   <= '0;
            snap_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_q == POLL_END) begin
                        cnt_q   <= '0;
                        latch_q <= 1'b1;
                        state_q <= S_LATCH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cnt_q == LATCH_END) begin
                        cnt_q   <= '0;
                        latch_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    for (int p = 0; p < NP; p++) asm_q[p][idx_q] <= ~sync2_q[p];
                    if (idx_q == 3'd7) begin
                        state_q <= S_COMMIT;
                    end else begin
                        pclk_q  <= 1'b1;
                        state_q <= S_CLK_HI;
                    end
                end
                S_CLK_HI: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q   <= '0;
                        pclk_q  <= 1'b0;
                        state_q <= S_CLK_LO;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CLK_LO: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    snap_q  <= asm_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O_pad_latch = latch_q;
    assign O_pad_clock = pclk_q;

    // Host side: writes act on the rising edge of wren, shifts on the falling edge of rden.
    assign wr_4016  = I_host_wren & ~wren_q & ~I_host_addr;
    assign rd_fall  = rden_q & ~I_host_rden;
    assign strobe_d = wr_4016 ? I_host_data[0] : strobe_q;

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            rd_addr_q <= 1'b0;
            strobe_q  <= 1'b0;
            shift_q   <= '0;
        end else begin
            wren_q   <= I_host_wren;
            rden_q   <= I_host_rden;
            strobe_q <= strobe_d;
            if (I_host_rden) rd_addr_q <= I_host_addr;
            for (int p = 0; p < NP; p++) begin
                if (strobe_q)
                    shift_q[p] <= snap_q[p];
                else if (rd_fall && !wr_4016 && rd_addr_q == 1'(p))
                    shift_q[p] <= {1'b1, shift_q[p][7:1]};
            end
        end
    end

`ifdef JOYPAD_PAD2_EN
    assign O_host_data = {7'b0100000, shift_q[I_host_addr][0]};
    assign O_pad_state = {snap_q[1], snap_q[0]};
`else
    logic unused_pad1;
    assign unused_pad1 = I_pad_data[1];
    assign O_host_data = {7'b0100000, shift_q[0][0] & ~I_host_addr};
    assign O_pad_state = {8'h00, snap_q[0]};
`endif

endmodule
